// File: rtl/histogram_readout_if.sv
// Result stream between histogram_readout and the host-side logger:
// one histogram bin per word, closed by a mismatch-count trailer.
interface histogram_readout_if #(
  parameter int MW = 16
);
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_idx;
  logic [MW-1:0] out_data;
  logic          out_last;

  modport master (output out_valid, output out_idx, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/histogram_readout.sv
// Snapshots the packed transition histogram on the end-of-run pulse and streams it
// bin by bin, followed by a trailer holding the saturating count of mismatch cycles.
module histogram_readout #(
  parameter int N  = 37,
  parameter int CW = 11,
  parameter int MW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   isequal,
  input  logic                   done,
  input  logic [CW*(N/2)-1:0]    registers,
  histogram_readout_if.master    stream,
  output logic                   busy,
  output logic                   overrun
);
  localparam int NB = N / 2;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0]    LAST_IDX = 8'(NB);
  localparam logic [MW-1:0] MCNT_MAX = {MW{1'b1}};
  localparam logic [MW-1:0] MCNT_ONE = MW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    idx_r, idx_s;
  logic [CW-1:0] shadow_r [NB];
  logic [MW-1:0] trailer_r;
  logic [MW-1:0] mcnt_r;
  logic          overrun_r;
  logic          accept_s;
  logic          capture_s;
  logic          trailer_done_s;
  logic [IW-1:0] sel_s;

  assign accept_s       = (state_r == SEND) && stream.out_ready;
  assign trailer_done_s = accept_s && (idx_r == LAST_IDX);
  assign sel_s          = idx_r[IW-1:0];

  // FSM state and word index registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state and index logic
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (done) begin
          state_s = ARM;
        end else begin
          state_s = IDLE;
        end
      end
      ARM: begin
        state_s   = SEND;
        idx_s     = 8'd0;
        capture_s = 1'b1;
      end
      SEND: begin
        if (accept_s) begin
          if (idx_r == LAST_IDX) begin
            state_s = IDLE;
            idx_s   = 8'd0;
          end else begin
            idx_s = idx_r + 8'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 8'd0;
      end
    endcase
  end

  // Snapshot of bins and mismatch count, taken on the closing edge of ARM
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NB; j++) begin
        shadow_r[j] <= {CW{1'b0}};
      end
      trailer_r <= {MW{1'b0}};
    end else if (capture_s) begin
      for (int j = 0; j < NB; j++) begin
        shadow_r[j] <= registers[j*CW +: CW];
      end
      trailer_r <= mcnt_r;
    end else begin
      trailer_r <= trailer_r;
    end
  end

  // Saturating mismatch counter; counts only in IDLE and never on the done edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcnt_r <= {MW{1'b0}};
    end else if (trailer_done_s) begin
      mcnt_r <= {MW{1'b0}};
    end else if ((state_r == IDLE) && run && !isequal && !done && (mcnt_r != MCNT_MAX)) begin
      mcnt_r <= mcnt_r + MCNT_ONE;
    end else begin
      mcnt_r <= mcnt_r;
    end
  end

  // Sticky flag for an end-of-run pulse that arrives while a readout is in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_r <= 1'b0;
    end else if (done && (state_r != IDLE)) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Stream outputs decoded from state and index only, so valid never waits on ready
  always_comb begin
    stream.out_valid = 1'b0;
    stream.out_idx   = 8'd0;
    stream.out_data  = {MW{1'b0}};
    stream.out_last  = 1'b0;
    if (state_r == SEND) begin
      stream.out_valid = 1'b1;
      stream.out_idx   = idx_r;
      if (idx_r < LAST_IDX) begin
        stream.out_data = MW'(shadow_r[sel_s]);
        stream.out_last = 1'b0;
      end else begin
        stream.out_data = trailer_r;
        stream.out_last = 1'b1;
      end
    end else begin
      stream.out_valid = 1'b0;
    end
  end

  assign busy    = (state_r != IDLE);
  assign overrun = overrun_r;
endmodule

// File: tb/tb_histogram_readout.sv
// Directed bench for histogram_readout: reset, readout timing, backpressure,
// mismatch trailer with saturation, overrun and reset in mid-stream.
module tb_histogram_readout;
  localparam int N  = 37;
  localparam int NB = 18;
  localparam int CW = 11;
  localparam int MW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             isequal;
  logic             done;
  logic [CW*NB-1:0] registers;
  logic             busy;
  logic             overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0]    got_idx  [64];
  logic [MW-1:0] got_data [64];
  logic          got_last [64];
  int            got_n;
  int            send_cyc;
  int            hold_bad;
  int            first_valid;
  bit            timeout;

  histogram_readout_if #(.MW(MW)) hif ();

  histogram_readout #(.N(N), .CW(CW), .MW(MW)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .isequal  (isequal),
    .done     (done),
    .registers(registers),
    .stream   (hif.master),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic load_bins(input int base);
    for (int j = 0; j < NB; j++) registers[j*CW +: CW] = CW'(base + j);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
  endtask

  // Consumer: records accepted words; mode 0 = always ready, mode 1 = ready on alternate SEND cycles.
  task automatic drain(input int mode, input int inject_at, input int abort_at);
    bit            fin = 1'b0;
    bit            held = 1'b0;
    bit            scrambled = 1'b0;
    logic [7:0]    h_idx = 8'd0;
    logic [MW-1:0] h_data = '0;
    logic          h_last = 1'b0;
    got_n = 0; send_cyc = 0; hold_bad = 0; first_valid = -1; timeout = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (hif.out_valid && !scrambled) begin
        registers = ~registers;
        scrambled = 1'b1;
      end
      if (hif.out_valid) hif.out_ready = (mode == 0) ? 1'b1 : ((send_cyc % 2) == 0);
      else hif.out_ready = 1'b1;
      done = (hif.out_valid && (int'(hif.out_idx) == inject_at)) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (hif.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        send_cyc++;
        if (held && (hif.out_idx !== h_idx || hif.out_data !== h_data || hif.out_last !== h_last))
          hold_bad++;
        if (hif.out_ready) begin
          if (got_n < 64) begin
            got_idx[got_n] = hif.out_idx;
            got_data[got_n] = hif.out_data;
            got_last[got_n] = hif.out_last;
          end
          got_n++;
          held = 1'b0;
          if (hif.out_last || int'(hif.out_idx) == abort_at) fin = 1'b1;
        end else begin
          held = 1'b1; h_idx = hif.out_idx; h_data = hif.out_data; h_last = hif.out_last;
        end
      end
      @(posedge clk); #1;
    end
    done = 1'b0;
    hif.out_ready = 1'b0;
    if (!fin) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      run = 1'($urandom); isequal = 1'($urandom); done = 1'($urandom);
      hif.out_ready = 1'($urandom);
      for (int j = 0; j < NB; j++) registers[j*CW +: CW] = CW'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (hif.out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || hif.out_data !== 16'd0 ||
        hif.out_idx !== 8'd0 || hif.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b overrun=%b data=%0d idx=%0d last=%b, want all 0",
               hif.out_valid, busy, overrun, hif.out_data, hif.out_idx, hif.out_last);
    end
    @(posedge clk); #1;
    rst = 1'b1; done = 1'b0; run = 1'b0; isequal = 1'b1; hif.out_ready = 1'b1;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (hif.out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL reset_idle_valid: out_valid went 1 without done, want 0");
      end
    end
    hif.out_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [MW-1:0] exp_d;
    load_bins(1);
    run = 1'b0;
    pulse_done();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || hif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_arm: busy=%b valid=%b, want busy=1 valid=0", busy, hif.out_valid);
    end
    @(posedge clk); #1;
    drain(0, -1, -1);
    checks++;
    if (timeout || got_n != NB + 1 || first_valid != 0) begin
      errors++;
      $display("FAIL basic_count: words=%0d first_valid_cyc=%0d timeout=%0b, want 19 0 0", got_n, first_valid, timeout);
    end
    checks++;
    if (send_cyc != NB + 1) begin
      errors++;
      $display("FAIL basic_send_cycles: got %0d, want 19", send_cyc);
    end
    for (int k = 0; k <= NB && k < got_n; k++) begin
      if (k < NB) exp_d = MW'(k + 1); else exp_d = 16'd0;
      checks++;
      if (got_idx[k] !== 8'(k) || got_data[k] !== exp_d || got_last[k] !== (k == NB)) begin
        errors++;
        $display("FAIL basic_word%0d: got idx=%0d data=%0d last=%b, want idx=%0d data=%0d last=%b",
                 k, got_idx[k], got_data[k], got_last[k], k, exp_d, (k == NB));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: busy=%b valid=%b, want 0 0", busy, hif.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] exp_d;
    load_bins(1);
    pulse_done();
    drain(1, -1, -1);
    checks++;
    if (timeout || got_n != NB + 1 || send_cyc != 37 || hold_bad != 0) begin
      errors++;
      $display("FAIL bp_stream: words=%0d send_cycles=%0d hold_errors=%0d timeout=%0b, want 19 37 0 0",
               got_n, send_cyc, hold_bad, timeout);
    end
    for (int k = 0; k <= NB && k < got_n; k++) begin
      if (k < NB) exp_d = MW'(k + 1); else exp_d = 16'd0;
      checks++;
      if (got_idx[k] !== 8'(k) || got_data[k] !== exp_d) begin
        errors++;
        $display("FAIL bp_word%0d: got idx=%0d data=%0d, want idx=%0d data=%0d", k, got_idx[k], got_data[k], k, exp_d);
      end
    end
  endtask

  task automatic test_mismatch();
    load_bins(1);
    @(posedge clk); #1 run = 1'b1; isequal = 1'b0;
    repeat (5) @(posedge clk);
    #1 isequal = 1'b1;
    repeat (3) @(posedge clk);
    #1 isequal = 1'b0; done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    drain(0, -1, -1);
    run = 1'b0; isequal = 1'b1;
    checks++;
    if (timeout || got_n != NB + 1 || got_data[NB] !== 16'd5) begin
      errors++;
      $display("FAIL mismatch_trailer: words=%0d trailer=%0d, want 19 5", got_n, got_data[NB]);
    end
    @(posedge clk); #1 run = 1'b1; isequal = 1'b1;
    repeat (4) @(posedge clk);
    #1 run = 1'b0;
    pulse_done();
    drain(0, -1, -1);
    checks++;
    if (timeout || got_n != NB + 1 || got_data[NB] !== 16'd0) begin
      errors++;
      $display("FAIL mismatch_clear: words=%0d trailer=%0d, want 19 0", got_n, got_data[NB]);
    end
    @(posedge clk); #1 run = 1'b1; isequal = 1'b0;
    repeat (70000) @(posedge clk);
    #1 run = 1'b0; isequal = 1'b1;
    pulse_done();
    drain(0, -1, -1);
    checks++;
    if (timeout || got_n != NB + 1 || got_data[NB] !== 16'd65535) begin
      errors++;
      $display("FAIL mismatch_saturate: words=%0d trailer=%0d, want 19 65535", got_n, got_data[NB]);
    end
  endtask

  task automatic test_overrun();
    logic [MW-1:0] exp_d;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_initial: got %b, want 0", overrun);
    end
    load_bins(1);
    pulse_done();
    drain(0, 4, -1);
    checks++;
    if (timeout || got_n != NB + 1) begin
      errors++;
      $display("FAIL overrun_count: words=%0d timeout=%0b, want 19 0", got_n, timeout);
    end
    for (int k = 0; k <= NB && k < got_n; k++) begin
      if (k < NB) exp_d = MW'(k + 1); else exp_d = 16'd0;
      checks++;
      if (got_idx[k] !== 8'(k) || got_data[k] !== exp_d || got_last[k] !== (k == NB)) begin
        errors++;
        $display("FAIL overrun_word%0d: got idx=%0d data=%0d last=%b, want idx=%0d data=%0d last=%b",
                 k, got_idx[k], got_data[k], got_last[k], k, exp_d, (k == NB));
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, want 1", overrun);
    end
    load_bins(1);
    pulse_done();
    drain(0, -1, -1);
    checks++;
    if (timeout || got_n != NB + 1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: words=%0d overrun=%b, want 19 1", got_n, overrun);
    end
  endtask

  task automatic test_reset_midstream();
    logic [MW-1:0] exp_d;
    load_bins(1);
    pulse_done();
    drain(0, -1, 7);
    checks++;
    if (timeout || got_n != 8 || got_idx[7] !== 8'd7) begin
      errors++;
      $display("FAIL midrst_progress: words=%0d last_idx=%0d, want 8 7", got_n, got_idx[7]);
    end
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (hif.out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: valid=%b busy=%b overrun=%b, want 0 0 0", hif.out_valid, busy, overrun);
    end
    load_bins(100);
    pulse_done();
    drain(0, -1, -1);
    checks++;
    if (timeout || got_n != NB + 1) begin
      errors++;
      $display("FAIL midrst_restart_count: words=%0d timeout=%0b, want 19 0", got_n, timeout);
    end
    for (int k = 0; k <= NB && k < got_n; k++) begin
      if (k < NB) exp_d = MW'(100 + k); else exp_d = 16'd0;
      checks++;
      if (got_idx[k] !== 8'(k) || got_data[k] !== exp_d) begin
        errors++;
        $display("FAIL midrst_word%0d: got idx=%0d data=%0d, want idx=%0d data=%0d", k, got_idx[k], got_data[k], k, exp_d);
      end
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; isequal = 1'b1; done = 1'b0;
    registers = '0; hif.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_mismatch();
    test_overrun();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
